// File: rtl/mips_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mips_bus_arbiter_if
// Groups the two requester handshakes (instruction fetch, data load/store)
// and the Avalon-style memory master bus that the arbiter shares between them.
//
// Handshake: a requester holds its request level (i_req, or d_read/d_write)
// until it sees its one-cycle done pulse (i_done / d_done), and drops it no
// later than the cycle after done. Read data (i_rdata / d_rdata) is valid
// from the done cycle and holds until the next done of the same side.
// On the bus, avm_read/avm_write stay high and avm_* stay constant until an
// edge with avm_waitrequest=0; avm_readdata is taken at that edge.
//
// Modports:
//   master : arbiter view (drives done/rdata to requesters, masters the bus)
//   slave  : environment view (requesters plus the memory slave)
// ---------------------------------------------------------------------------
interface mips_bus_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteenable;
    logic [31:0] d_rdata;
    logic        d_done;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
        input  avm_waitrequest, avm_readdata,
        output i_rdata, i_done, d_rdata, d_done,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );

    modport slave (
        output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_byteenable,
        output avm_waitrequest, avm_readdata,
        input  i_rdata, i_done, d_rdata, d_done,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mips_bus_arbiter
// Shares one Avalon-style master port between the instruction-fetch and the
// data load/store requesters of a Harvard core. A granted request is captured
// into the avm_* registers, one bus transfer is run (waiting out
// waitrequest), read data is returned and a one-cycle done pulse is issued.
// A waitrequest timeout aborts a transfer to a hung slave.
//
// Parameters:
//   TIMEOUT : max consecutive waitrequest cycles in a bus state before abort
//             (0 disables the timeout; counter is 16 bits)
// Optional feature macro:
//   ARB_ROUND_ROBIN_EN : when defined, conflicting requests alternate using a
//                        last_grant register; otherwise data always wins.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   bus         : requester handshakes + Avalon master (mips_bus_arbiter_if)
//   busy        : high whenever the FSM is not IDLE
//   bus_error   : sticky timeout flag, cleared only by reset
//   o_dbg_state : current FSM state
// ---------------------------------------------------------------------------
module mips_bus_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_bus_arbiter_if.master     bus,
    output logic                   busy,
    output logic                   bus_error,
    output logic [1:0]             o_dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);
    localparam bit          LP_TO_EN   = (TIMEOUT != 0);

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_avm_address;
    logic        r_avm_read;
    logic        r_avm_write;
    logic [31:0] r_avm_writedata;
    logic [3:0]  r_avm_byteenable;
    logic [31:0] r_i_rdata;
    logic [31:0] r_d_rdata;
    logic        r_i_done;
    logic        r_d_done;
    logic        r_busy;
    logic        r_bus_error;
    logic [15:0] r_wait_cnt;

    logic        w_d_req;
    logic        w_grant_d;
    logic        w_grant_i;
    logic [15:0] w_cnt_inc;
    logic        w_timeout;
    logic        w_xfer_end;

    assign w_d_req = bus.d_read | bus.d_write;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = data side was granted last; reset value makes fetch win the first conflict.
    logic r_last_grant_d;
    assign w_grant_d = w_d_req & (~bus.i_req | ~r_last_grant_d);
`else
    assign w_grant_d = w_d_req;
`endif
    assign w_grant_i = bus.i_req & ~w_grant_d;

    // Abort on the wait cycle whose increment would make the counter reach TIMEOUT.
    assign w_cnt_inc  = r_wait_cnt + 16'd1;
    assign w_timeout  = LP_TO_EN && bus.avm_waitrequest && (w_cnt_inc == LP_TIMEOUT);
    assign w_xfer_end = ~bus.avm_waitrequest | w_timeout;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_next = BUS_D;
                end else if (w_grant_i) begin
                    w_state_next = BUS_I;
                end
            end
            BUS_I, BUS_D: begin
                if (w_xfer_end) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= IDLE;
            r_avm_address    <= 32'd0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_writedata  <= 32'd0;
            r_avm_byteenable <= 4'd0;
            r_i_rdata        <= 32'd0;
            r_d_rdata        <= 32'd0;
            r_i_done         <= 1'b0;
            r_d_done         <= 1'b0;
            r_busy           <= 1'b0;
            r_bus_error      <= 1'b0;
            r_wait_cnt       <= 16'd0;
        end else begin
            r_state  <= w_state_next;
            r_busy   <= (w_state_next != IDLE);
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_wait_cnt <= 16'd0;
                    if (w_grant_d) begin
                        // Write takes precedence when d_read and d_write are both high.
                        r_avm_address    <= bus.d_addr;
                        r_avm_writedata  <= bus.d_wdata;
                        r_avm_byteenable <= bus.d_byteenable;
                        r_avm_write      <= bus.d_write;
                        r_avm_read       <= ~bus.d_write;
                    end else if (w_grant_i) begin
                        r_avm_address    <= bus.i_addr;
                        r_avm_writedata  <= 32'd0;
                        r_avm_byteenable <= 4'b1111;
                        r_avm_write      <= 1'b0;
                        r_avm_read       <= 1'b1;
                    end
                end
                BUS_I, BUS_D: begin
                    if (w_xfer_end) begin
                        r_avm_read  <= 1'b0;
                        r_avm_write <= 1'b0;
                        if (w_timeout) begin
                            r_bus_error <= 1'b1;
                        end
                        if (r_state == BUS_I) begin
                            r_i_done <= 1'b1;
                            if (w_timeout) begin
                                r_i_rdata <= 32'hFFFF_FFFF;
                            end else if (r_avm_read) begin
                                r_i_rdata <= bus.avm_readdata;
                            end
                        end else begin
                            r_d_done <= 1'b1;
                            if (w_timeout) begin
                                r_d_rdata <= 32'hFFFF_FFFF;
                            end else if (r_avm_read) begin
                                r_d_rdata <= bus.avm_readdata;
                            end
                        end
                    end else begin
                        r_wait_cnt <= w_cnt_inc;
                    end
                end
                DONE:    r_wait_cnt <= 16'd0;
                default: r_wait_cnt <= 16'd0;
            endcase
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant_d <= 1'b1;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                r_last_grant_d <= 1'b1;
            end else if (w_grant_i) begin
                r_last_grant_d <= 1'b0;
            end
        end
    end
`endif

    assign bus.avm_address    = r_avm_address;
    assign bus.avm_read       = r_avm_read;
    assign bus.avm_write      = r_avm_write;
    assign bus.avm_writedata  = r_avm_writedata;
    assign bus.avm_byteenable = r_avm_byteenable;
    assign bus.i_rdata        = r_i_rdata;
    assign bus.i_done         = r_i_done;
    assign bus.d_rdata        = r_d_rdata;
    assign bus.d_done         = r_d_done;
    assign busy               = r_busy;
    assign bus_error          = r_bus_error;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mips_bus_arbiter
// Directed bench for mips_bus_arbiter (TIMEOUT=4). A table of per-cycle
// {inputs, expected outputs} rows covers single fetch, waited store, data
// read, read+write collision, back-to-back fetches and a request conflict
// after a fetch; hand-written sequences cover timeout, reset mid-transfer and
// the first conflict after reset.
// ---------------------------------------------------------------------------
module tb_mips_bus_arbiter;

    typedef struct packed {
        logic        ireq;
        logic [31:0] iaddr;
        logic        drd;
        logic        dwr;
        logic [31:0] daddr;
        logic [31:0] dwd;
        logic [3:0]  dbe;
        logic        wreq;
        logic [31:0] rdat;
    } in_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] irdata;
        logic        idone;
        logic [31:0] drdata;
        logic        ddone;
        logic        busy;
        logic        berr;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       busy;
    logic       bus_error;
    logic [1:0] dbg_state;
    int         total;
    int         bad;
    logic       mon_en;
    vec_t       vecs[$];

    mips_bus_arbiter_if bus_if ();

    mips_bus_arbiter #(.TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if),
        .busy        (busy),
        .bus_error   (bus_error),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(logic ireq, logic [31:0] iaddr, logic drd, logic dwr,
                                  logic [31:0] daddr, logic [31:0] dwd, logic [3:0] dbe,
                                  logic wreq, logic [31:0] rdat);
        in_t v;
        v = '{ireq, iaddr, drd, dwr, daddr, dwd, dbe, wreq, rdat};
        return v;
    endfunction

    function automatic out_t mk_out(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                                    logic [3:0] be, logic [31:0] irdata, logic idone,
                                    logic [31:0] drdata, logic ddone, logic bsy, logic berr);
        out_t v;
        v = '{rd, wr, addr, wdata, be, irdata, idone, drdata, ddone, bsy, berr};
        return v;
    endfunction

    function automatic in_t idle_in();
        return mk_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0);
    endfunction

    function automatic out_t actual();
        out_t a;
        a = '{bus_if.avm_read, bus_if.avm_write, bus_if.avm_address, bus_if.avm_writedata,
              bus_if.avm_byteenable, bus_if.i_rdata, bus_if.i_done, bus_if.d_rdata,
              bus_if.d_done, busy, bus_error};
        return a;
    endfunction

    // driver tasks
    task automatic drive(input in_t v);
        bus_if.i_req           = v.ireq;
        bus_if.i_addr          = v.iaddr;
        bus_if.d_read          = v.drd;
        bus_if.d_write         = v.dwr;
        bus_if.d_addr          = v.daddr;
        bus_if.d_wdata         = v.dwd;
        bus_if.d_byteenable    = v.dbe;
        bus_if.avm_waitrequest = v.wreq;
        bus_if.avm_readdata    = v.rdat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboard
    task automatic check(input string name, input out_t exp);
        out_t a;
        a = actual();
        total++;
        if (a !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, a, exp);
        end
    endtask

    task automatic add(input string name, input in_t i, input out_t o);
        vec_t v;
        v.name = name;
        v.in   = i;
        v.exp  = o;
        vecs.push_back(v);
    endtask

    // Strobe exclusivity and strobes only while busy, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ((bus_if.avm_read && bus_if.avm_write) ||
                ((bus_if.avm_read || bus_if.avm_write) && !busy)) begin
                bad++;
                $display("FAIL strobe_rule rd=%b wr=%b busy=%b", bus_if.avm_read,
                         bus_if.avm_write, busy);
            end
        end
    end

    initial begin
        total  = 0;
        bad    = 0;
        mon_en = 1'b0;

        // fetch only, no wait
        add("f_strobe", mk_in(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0),
            mk_out(1, 0, 32'hBFC00000, 0, 4'hF, 0, 0, 0, 0, 1, 0));
        add("f_done",   mk_in(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 32'h2402000A),
            mk_out(0, 0, 32'hBFC00000, 0, 4'hF, 32'h2402000A, 1, 0, 0, 1, 0));
        add("f_idle",   idle_in(),
            mk_out(0, 0, 32'hBFC00000, 0, 4'hF, 32'h2402000A, 0, 0, 0, 0, 0));
        // store, two wait cycles, inputs change mid-transfer
        add("s_w0",   mk_in(0, 0, 0, 1, 32'h1004, 32'hDEADBEEF, 4'h3, 1, 0),
            mk_out(0, 1, 32'h1004, 32'hDEADBEEF, 4'h3, 32'h2402000A, 0, 0, 0, 1, 0));
        add("s_w1",   mk_in(0, 0, 0, 1, 32'h2000, 32'h11111111, 4'hF, 1, 32'h55555555),
            mk_out(0, 1, 32'h1004, 32'hDEADBEEF, 4'h3, 32'h2402000A, 0, 0, 0, 1, 0));
        add("s_w2",   mk_in(0, 0, 0, 1, 32'h2000, 32'h11111111, 4'hF, 1, 32'h55555555),
            mk_out(0, 1, 32'h1004, 32'hDEADBEEF, 4'h3, 32'h2402000A, 0, 0, 0, 1, 0));
        add("s_done", mk_in(0, 0, 0, 1, 32'h2000, 32'h11111111, 4'hF, 0, 32'h66666666),
            mk_out(0, 0, 32'h1004, 32'hDEADBEEF, 4'h3, 32'h2402000A, 0, 0, 1, 1, 0));
        add("s_idle", idle_in(),
            mk_out(0, 0, 32'h1004, 32'hDEADBEEF, 4'h3, 32'h2402000A, 0, 0, 0, 0, 0));
        // d_read and d_write together: write only
        add("rw_strobe", mk_in(0, 0, 1, 1, 32'h3000, 32'hCAFEF00D, 4'hF, 0, 0),
            mk_out(0, 1, 32'h3000, 32'hCAFEF00D, 4'hF, 32'h2402000A, 0, 0, 0, 1, 0));
        add("rw_done",   mk_in(0, 0, 1, 1, 32'h3000, 32'hCAFEF00D, 4'hF, 0, 32'h77777777),
            mk_out(0, 0, 32'h3000, 32'hCAFEF00D, 4'hF, 32'h2402000A, 0, 0, 1, 1, 0));
        add("rw_idle",   idle_in(),
            mk_out(0, 0, 32'h3000, 32'hCAFEF00D, 4'hF, 32'h2402000A, 0, 0, 0, 0, 0));
        // data read
        add("dr_strobe", mk_in(0, 0, 1, 0, 32'h4000, 0, 4'h4, 0, 0),
            mk_out(1, 0, 32'h4000, 0, 4'h4, 32'h2402000A, 0, 0, 0, 1, 0));
        add("dr_done",   mk_in(0, 0, 1, 0, 32'h4000, 0, 4'h4, 0, 32'h12345678),
            mk_out(0, 0, 32'h4000, 0, 4'h4, 32'h2402000A, 0, 32'h12345678, 1, 1, 0));
        add("dr_idle",   idle_in(),
            mk_out(0, 0, 32'h4000, 0, 4'h4, 32'h2402000A, 0, 32'h12345678, 0, 0, 0));
        // back-to-back fetches, request held through done
        add("bb_s0", mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0),
            mk_out(1, 0, 32'h100, 0, 4'hF, 32'h2402000A, 0, 32'h12345678, 0, 1, 0));
        add("bb_d0", mk_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 32'hAAAA0001),
            mk_out(0, 0, 32'h100, 0, 4'hF, 32'hAAAA0001, 1, 32'h12345678, 0, 1, 0));
        add("bb_i0", mk_in(1, 32'h104, 0, 0, 0, 0, 0, 0, 0),
            mk_out(0, 0, 32'h100, 0, 4'hF, 32'hAAAA0001, 0, 32'h12345678, 0, 0, 0));
        add("bb_s1", mk_in(1, 32'h104, 0, 0, 0, 0, 0, 0, 0),
            mk_out(1, 0, 32'h104, 0, 4'hF, 32'hAAAA0001, 0, 32'h12345678, 0, 1, 0));
        add("bb_d1", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'hAAAA0002),
            mk_out(0, 0, 32'h104, 0, 4'hF, 32'hAAAA0002, 1, 32'h12345678, 0, 1, 0));
        add("bb_i1", idle_in(),
            mk_out(0, 0, 32'h104, 0, 4'hF, 32'hAAAA0002, 0, 32'h12345678, 0, 0, 0));
        // conflict after a fetch grant: data wins in both builds
        add("c_ds", mk_in(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 0),
            mk_out(1, 0, 32'h300, 0, 4'hF, 32'hAAAA0002, 0, 32'h12345678, 0, 1, 0));
        add("c_dd", mk_in(1, 32'h200, 1, 0, 32'h300, 0, 4'hF, 0, 32'hD0D0D0D0),
            mk_out(0, 0, 32'h300, 0, 4'hF, 32'hAAAA0002, 0, 32'hD0D0D0D0, 1, 1, 0));
        add("c_i0", mk_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 0),
            mk_out(0, 0, 32'h300, 0, 4'hF, 32'hAAAA0002, 0, 32'hD0D0D0D0, 0, 0, 0));
        add("c_fs", mk_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 0),
            mk_out(1, 0, 32'h200, 0, 4'hF, 32'hAAAA0002, 0, 32'hD0D0D0D0, 0, 1, 0));
        add("c_fd", mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'hF0F0F0F0),
            mk_out(0, 0, 32'h200, 0, 4'hF, 32'hF0F0F0F0, 1, 32'hD0D0D0D0, 0, 1, 0));
        add("c_i1", idle_in(),
            mk_out(0, 0, 32'h200, 0, 4'hF, 32'hF0F0F0F0, 0, 32'hD0D0D0D0, 0, 0, 0));

        // reset
        reset = 1'b1;
        drive(idle_in());
        step();
        step();
        check("reset_out", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        total++;
        if (dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        reset = 1'b0;
        mon_en = 1'b1;

        foreach (vecs[k]) begin
            drive(vecs[k].in);
            step();
            check(vecs[k].name, vecs[k].exp);
        end

        // timeout: waitrequest stuck high on a fetch
        drive(mk_in(1, 32'h500, 0, 0, 0, 0, 0, 1, 0));
        step();
        check("to_strobe", mk_out(1, 0, 32'h500, 0, 4'hF, 32'hF0F0F0F0, 0, 32'hD0D0D0D0, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            step();
            check("to_wait", mk_out(1, 0, 32'h500, 0, 4'hF, 32'hF0F0F0F0, 0, 32'hD0D0D0D0, 0, 1, 0));
        end
        step();
        check("to_abort", mk_out(0, 0, 32'h500, 0, 4'hF, 32'hFFFFFFFF, 1, 32'hD0D0D0D0, 0, 1, 1));
        drive(idle_in());
        step();
        check("to_idle", mk_out(0, 0, 32'h500, 0, 4'hF, 32'hFFFFFFFF, 0, 32'hD0D0D0D0, 0, 0, 1));

        // 3 wait cycles after a timeout must not abort (counter cleared)
        drive(mk_in(1, 32'h504, 0, 0, 0, 0, 0, 1, 0));
        step();
        check("w3_strobe", mk_out(1, 0, 32'h504, 0, 4'hF, 32'hFFFFFFFF, 0, 32'hD0D0D0D0, 0, 1, 1));
        for (int k = 0; k < 3; k++) begin
            step();
            check("w3_wait", mk_out(1, 0, 32'h504, 0, 4'hF, 32'hFFFFFFFF, 0, 32'hD0D0D0D0, 0, 1, 1));
        end
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h0BADF00D));
        step();
        check("w3_done", mk_out(0, 0, 32'h504, 0, 4'hF, 32'h0BADF00D, 1, 32'hD0D0D0D0, 0, 1, 1));
        drive(idle_in());
        step();
        check("err_sticky", mk_out(0, 0, 32'h504, 0, 4'hF, 32'h0BADF00D, 0, 32'hD0D0D0D0, 0, 0, 1));

        // reset in the middle of BUS_D wait cycles
        drive(mk_in(0, 0, 1, 0, 32'h600, 0, 4'hF, 1, 0));
        step();
        check("rs_strobe", mk_out(1, 0, 32'h600, 0, 4'hF, 32'h0BADF00D, 0, 32'hD0D0D0D0, 0, 1, 1));
        step();
        check("rs_wait", mk_out(1, 0, 32'h600, 0, 4'hF, 32'h0BADF00D, 0, 32'hD0D0D0D0, 0, 1, 1));
        reset = 1'b1;
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 1, 0));
        step();
        check("rs_clear", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        drive(idle_in());
        for (int k = 0; k < 2; k++) begin
            step();
            check("rs_no_done", mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end

        // first conflict after reset
        drive(mk_in(1, 32'hBFC00000, 1, 0, 32'h700, 0, 4'hF, 0, 0));
        step();
`ifdef ARB_ROUND_ROBIN_EN
        check("rc_s0", mk_out(1, 0, 32'hBFC00000, 0, 4'hF, 0, 0, 0, 0, 1, 0));
        drive(mk_in(1, 32'hBFC00000, 1, 0, 32'h700, 0, 4'hF, 0, 32'h55667788));
        step();
        check("rc_d0", mk_out(0, 0, 32'hBFC00000, 0, 4'hF, 32'h55667788, 1, 0, 0, 1, 0));
        drive(mk_in(0, 0, 1, 0, 32'h700, 0, 4'hF, 0, 0));
        step();
        check("rc_i0", mk_out(0, 0, 32'hBFC00000, 0, 4'hF, 32'h55667788, 0, 0, 0, 0, 0));
        step();
        check("rc_s1", mk_out(1, 0, 32'h700, 0, 4'hF, 32'h55667788, 0, 0, 0, 1, 0));
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h11223344));
        step();
        check("rc_d1", mk_out(0, 0, 32'h700, 0, 4'hF, 32'h55667788, 0, 32'h11223344, 1, 1, 0));
        drive(idle_in());
        step();
        check("rc_i1", mk_out(0, 0, 32'h700, 0, 4'hF, 32'h55667788, 0, 32'h11223344, 0, 0, 0));
`else
        check("rc_s0", mk_out(1, 0, 32'h700, 0, 4'hF, 0, 0, 0, 0, 1, 0));
        drive(mk_in(1, 32'hBFC00000, 1, 0, 32'h700, 0, 4'hF, 0, 32'h11223344));
        step();
        check("rc_d0", mk_out(0, 0, 32'h700, 0, 4'hF, 0, 0, 32'h11223344, 1, 1, 0));
        drive(mk_in(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0));
        step();
        check("rc_i0", mk_out(0, 0, 32'h700, 0, 4'hF, 0, 0, 32'h11223344, 0, 0, 0));
        step();
        check("rc_s1", mk_out(1, 0, 32'hBFC00000, 0, 4'hF, 0, 0, 32'h11223344, 0, 1, 0));
        drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h55667788));
        step();
        check("rc_d1", mk_out(0, 0, 32'hBFC00000, 0, 4'hF, 32'h55667788, 1, 32'h11223344, 0, 1, 0));
        drive(idle_in());
        step();
        check("rc_i1", mk_out(0, 0, 32'hBFC00000, 0, 4'hF, 32'h55667788, 0, 32'h11223344, 0, 0, 0));
`endif

        // final report
        mon_en = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
